// File: rtl/booth_pkg.sv
// Shared definitions for the Booth multiplier arbiter: FSM encoding,
// default operand width, Booth recoding pair codes and the port pick rule.
package booth_pkg;

  localparam int W_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // {Qr[0], q_1} pairs that change the accumulator; 00 and 11 leave it alone.
  localparam logic [1:0] PAIR_SUB = 2'b10;
  localparam logic [1:0] PAIR_ADD = 2'b01;

  // Winner of one arbitration round: a lone requester always wins, a tie
  // goes to the port named by the round-robin pointer.
  function automatic logic pick_port(input logic req0, input logic req1, input logic ptr);
    pick_port = (req0 & req1) ? ptr : req1;
  endfunction

endpackage

// File: rtl/booth_mul_arbiter_if.sv
// Client-side bus of the shared multiplier: two request/ack ports with
// operands, plus the shared tagged result bus and busy flag.
interface booth_mul_arbiter_if #(
  parameter int W = booth_pkg::W_DEFAULT
) ();

  logic           req0;
  logic [W-1:0]   m0;
  logic [W-1:0]   q0;
  logic           ack0;
  logic           req1;
  logic [W-1:0]   m1;
  logic [W-1:0]   q1;
  logic           ack1;
  logic [2*W-1:0] out;
  logic           out_valid;
  logic           out_id;
  logic           busy;

  modport master (
    output req0, m0, q0, req1, m1, q1,
    input  ack0, ack1, out, out_valid, out_id, busy
  );

  modport slave (
    input  req0, m0, q0, req1, m1, q1,
    output ack0, ack1, out, out_valid, out_id, busy
  );

endinterface

// File: rtl/booth_seq_core.sv
// Sequential radix-2 Booth multiplier datapath. A pulse on load captures
// the operands; the core then runs one Booth step per cycle until its
// down-counter reaches zero. The accumulator is W+1 bits so that a
// multiplicand of -2^(W-1) can be negated without overflow.
module booth_seq_core
  import booth_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic [W-1:0]   m,
  input  logic [W-1:0]   q,
  output logic [2*W-1:0] product,
  output logic           done
);

  localparam int CW = $clog2(W + 1);

  logic [W:0]    acc;
  logic [W:0]    mcand;
  logic [W:0]    sum;
  logic [W-1:0]  qr;
  logic          q_1;
  logic [CW-1:0] count;

  // Booth recoding: add, subtract or pass the multiplicand for this step.
  always_comb begin
    sum = acc;
    case ({qr[0], q_1})
      PAIR_SUB: sum = acc - mcand;
      PAIR_ADD: sum = acc + mcand;
      default:  sum = acc;
    endcase
  end

  // Operand load, then one arithmetic right shift of {A, Qr, q_1} per step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc   <= '0;
      mcand <= '0;
      qr    <= '0;
      q_1   <= 1'b0;
      count <= '0;
    end else if (load) begin
      acc   <= '0;
      mcand <= {m[W-1], m};
      qr    <= q;
      q_1   <= 1'b0;
      count <= CW'(W);
    end else if (count != '0) begin
      acc   <= {sum[W], sum[W:1]};
      qr    <= {sum[0], qr[W-1:1]};
      q_1   <= qr[0];
      count <= count - CW'(1);
    end
  end

  assign product = {acc[W-1:0], qr};
  // High during the cycle that performs the final step.
  assign done    = (count == CW'(1));

endmodule

// File: rtl/booth_mul_arbiter.sv
// Round-robin front end sharing one booth_seq_core between two clients.
// Grants one request per IDLE edge, captures that port's operands, runs
// the core and returns the product tagged with the requester id.
//
// state | meaning
// IDLE  | waiting for a request; arbitration and operand capture happen here
// LOAD  | ack to the granted port, core initialised from captured operands
// RUN   | W Booth steps in the core
// DONE  | product presented with out_valid and out_id
module booth_mul_arbiter
  import booth_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  booth_mul_arbiter_if.slave  bus
);

  state_t         state;
  state_t         state_nxt;
  logic           any_req;
  logic           winner;
  logic           ptr;
  logic           grant_id;
  logic [W-1:0]   m_reg;
  logic [W-1:0]   q_reg;
  logic [2*W-1:0] product;
  logic           core_done;
  logic [2*W-1:0] out_reg;
  logic           id_reg;

  assign any_req = bus.req0 | bus.req1;
  assign winner  = pick_port(bus.req0, bus.req1, ptr);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; requests only matter in IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (any_req) state_nxt = ST_LOAD;
      ST_LOAD: state_nxt = ST_RUN;
      ST_RUN:  if (core_done) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Grant bookkeeping: winner id, pointer hand-over and operand capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr      <= 1'b0;
      grant_id <= 1'b0;
      m_reg    <= '0;
      q_reg    <= '0;
    end else if (state == ST_IDLE && any_req) begin
      ptr      <= ~winner;
      grant_id <= winner;
      m_reg    <= winner ? bus.m1 : bus.m0;
      q_reg    <= winner ? bus.q1 : bus.q0;
    end
  end

  booth_seq_core #(.W(W)) u_core (
    .clk     (clk),
    .rst     (rst),
    .load    (state == ST_LOAD),
    .m       (m_reg),
    .q       (q_reg),
    .product (product),
    .done    (core_done)
  );

  // Keep the last delivered result and its owner on the bus between DONEs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_reg <= '0;
      id_reg  <= 1'b0;
    end else if (state == ST_DONE) begin
      out_reg <= product;
      id_reg  <= grant_id;
    end
  end

  assign bus.ack0      = (state == ST_LOAD) && !grant_id;
  assign bus.ack1      = (state == ST_LOAD) && grant_id;
  assign bus.out_valid = (state == ST_DONE);
  assign bus.out       = (state == ST_DONE) ? product : out_reg;
  assign bus.out_id    = (state == ST_DONE) ? grant_id : id_reg;
  assign bus.busy      = (state != ST_IDLE);

endmodule
